// File: rtl/dut_pkg.sv
// Shared types, address map and widths for the A*B*C product engine.
package dut_pkg;

   localparam int OP_W   = 8;
   localparam int P1_W   = 16;
   localparam int PROD_W = 24;

   localparam logic [7:0] ADDR_A  = 8'd0;
   localparam logic [7:0] ADDR_B  = 8'd1;
   localparam logic [7:0] ADDR_C  = 8'd2;
   localparam logic [7:0] ADDR_P0 = 8'd3;

   typedef enum logic [3:0] {
      IDLE, RD0, RD1, RD2, MUL1, MUL2, WR0, WR1, WR2, DONE
   } state_t;

   // Exact signed 8x8 product; operands are sign-extended before multiplying.
   function automatic logic signed [P1_W-1:0] mul_ab(input logic signed [OP_W-1:0] x,
                                                     input logic signed [OP_W-1:0] y);
      return P1_W'(x) * P1_W'(y);
   endfunction

   // Exact signed 16x8 product; the full range of A*B*C fits in 24 bits.
   function automatic logic signed [PROD_W-1:0] mul_pc(input logic signed [P1_W-1:0] x,
                                                       input logic signed [OP_W-1:0] y);
      return PROD_W'(x) * PROD_W'(y);
   endfunction

endpackage

// File: rtl/dut_data_mem.sv
// 256 x 8 data memory: asynchronous read, synchronous single-byte write, no reset.
module data_mem (
   input  logic       clk,
   input  logic       wr_en,
   input  logic [7:0] addr,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data
);

   logic [7:0] core [0:255];

   // Write port; a plain always block because software also loads core hierarchically.
   always @(posedge clk) begin
      if (wr_en) core[addr] <= wr_data;
   end

   assign rd_data = core[addr];

endmodule

// File: rtl/dut.sv
// Product engine: reads A, B, C from memory, computes A*B*C, writes 3 result bytes LSB first.
module dut
   import dut_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic done
);

   state_t                    state_q, state_d;
   logic                      start_q, start_d;
   logic signed [OP_W-1:0]    a_q, a_d;
   logic signed [OP_W-1:0]    b_q, b_d;
   logic signed [OP_W-1:0]    c_q, c_d;
   logic signed [P1_W-1:0]    p1_q, p1_d;
   logic signed [PROD_W-1:0]  p_q, p_d;

   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   data_mem dm (
      .clk     (clk),
      .wr_en   (mem_we),
      .addr    (mem_addr),
      .wr_data (mem_wdata),
      .rd_data (mem_rdata)
   );

   // State, start history and operand/product registers; start_q resets high so a held-low start runs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         start_q <= 1'b1;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         p1_q    <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         p1_q    <= p1_d;
         p_q     <= p_d;
      end
   end

   // Sequencer: one memory access or one multiply per state; start falls are only seen in IDLE.
   always_comb begin
      state_d   = state_q;
      start_d   = start;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      p1_d      = p1_q;
      p_d       = p_q;
      mem_we    = 1'b0;
      mem_addr  = ADDR_A;
      mem_wdata = 8'h00;
      case (state_q)
         IDLE: if (start_q && !start) state_d = RD0;
         RD0: begin
            mem_addr = ADDR_A;
            a_d      = $signed(mem_rdata);
            state_d  = RD1;
         end
         RD1: begin
            mem_addr = ADDR_B;
            b_d      = $signed(mem_rdata);
            state_d  = RD2;
         end
         RD2: begin
            mem_addr = ADDR_C;
            c_d      = $signed(mem_rdata);
            state_d  = MUL1;
         end
         MUL1: begin
            p1_d    = mul_ab(a_q, b_q);
            state_d = MUL2;
         end
         MUL2: begin
            p_d     = mul_pc(p1_q, c_q);
            state_d = WR0;
         end
         WR0: begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_P0;
            mem_wdata = p_q[7:0];
            state_d   = WR1;
         end
         WR1: begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_P0 + 8'd1;
            mem_wdata = p_q[15:8];
            state_d   = WR2;
         end
         WR2: begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_P0 + 8'd2;
            mem_wdata = p_q[23:16];
            state_d   = DONE;
         end
         DONE: if (start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign done = (state_q == DONE);

endmodule

// File: tb/tb_dut.sv
// Directed bench for the product engine: results, latency, handshake and mid-run reset.
module tb_dut;
   import dut_pkg::*;

   logic clk;
   logic reset;
   logic start;
   logic done;

   int checks = 0;
   int errors = 0;

   dut dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] result_bytes();
      return {dut.dm.core[5], dut.dm.core[4], dut.dm.core[3]};
   endfunction

   // One complete run; optionally toggles start mid-run, which must not restart it.
   task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [23:0] exp, input bit toggle);
      int n;
      dut.dm.core[0] <= a;
      dut.dm.core[1] <= b;
      dut.dm.core[2] <= c;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         if (toggle && n == 3) start = 1'b1;
         if (toggle && n == 4) start = 1'b0;
      end
      chk({tag, "_latency"}, n, 9);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_prod"}, result_bytes(), exp);
      start = 1'b1;
      @(negedge clk);
      chk({tag, "_done_fall"}, done, 0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_done", done, 0);
      chk("rst_state", dut.state_q, IDLE);
      chk("rst_p", dut.p_q, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_done", done, 0);

      run("r1", 8'd2, 8'hFC, 8'd8, 24'hFFFFC0, 1'b0);
      run("r2", 8'h80, 8'h80, 8'h80, 24'hE00000, 1'b0);
      run("r3", 8'd127, 8'd127, 8'd127, 24'h1F417F, 1'b0);
      run("r4", 8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF, 1'b0);
      run("r5", 8'd0, 8'd99, 8'hF9, 24'h000000, 1'b0);
      run("tog", 8'd3, 8'd5, 8'hFE, 24'hFFFFE2, 1'b1);

      // Reset asserted while the FSM is in WR1.
      dut.dm.core[0] <= 8'd2;
      dut.dm.core[1] <= 8'hFC;
      dut.dm.core[2] <= 8'd8;
      dut.dm.core[3] <= 8'hAA;
      dut.dm.core[4] <= 8'hAA;
      dut.dm.core[5] <= 8'hAA;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_rst_state", dut.state_q, WR1);
      start = 1'b1;
      reset = 1'b0;
      #1;
      chk("mid_rst_done", done, 0);
      chk("mid_rst_state", dut.state_q, IDLE);
      repeat (3) @(negedge clk);
      chk("mid_rst_opa", dut.dm.core[0], 8'd2);
      chk("mid_rst_opb", dut.dm.core[1], 8'hFC);
      chk("mid_rst_opc", dut.dm.core[2], 8'd8);
      chk("mid_rst_b4", dut.dm.core[4], 8'hAA);
      chk("mid_rst_b5", dut.dm.core[5], 8'hAA);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_state", dut.state_q, IDLE);
      run("r6", 8'd2, 8'hFC, 8'd8, 24'hFFFFC0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
